pid_terms_gen: RTL and testbench
================================

# pid_terms_gen

Fixed-point PID term generator: accepts one error sample per handshake and produces the integral, proportional and derivative terms that feed the `SumadorEcuaciones` equation adder. The adder combines them as ik − pk − dk. The block time-shares one saturating multiplier across the three terms under a small FSM. It keeps the integral accumulator and the previous error sample as internal state.

## Interface
- `N`, default 24: data width, signed two's complement; equals `N` in `constantes.h`.
- `FRAC`, default 12: fractional bits; 1.0 = 2^FRAC = 4096.
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: reset, synchronous, active-high.
- `in_valid`, in, 1: `error` is valid this cycle.
- `in_ready`, out, 1: high exactly when FSM is in IDLE.
- `error`, in, N: signed error sample.
- `kp`, `ki`, `kd`, in, N each: signed gains; sampled at accept.
- `clear_int`, in, 1: clears the integral accumulator.
- `out_valid`, out, 1: one-cycle pulse; `ik`, `pk`, `dk` are updated.
- `ik`, `pk`, `dk`, out, N each: signed terms; held between updates.

## Operation
- FSM states: IDLE, MUL_P, MUL_I, MUL_D, DONE.
- IDLE → MUL_P when `in_valid` is high. On this accept, latch `error` and the three gains.
- MUL_P → MUL_I → MUL_D → DONE → IDLE unconditionally.
- Fixed-point multiply, one rule for every product: full-width signed product, arithmetic shift right by FRAC, then saturate to [−2^(N−1), 2^(N−1)−1].
- MUL_P: pk_next = mul(kp, e).
- MUL_I: acc = sat(acc + mul(ki, e)). The sum is formed at N+1 bits before saturation.
- MUL_D: diff = e − e_prev at N+1 bits, unsaturated. dk_next = mul(kd, diff).
- DONE: update `pk`, `ik`, `dk` together, pulse `out_valid`, then set e_prev = e.
- `clear_int`:
  - In IDLE without accept: acc and `ik` become 0 on the next edge; `out_valid` stays low.
  - In IDLE together with an accept: this sample's integral starts from 0, so ik = mul(ki, e).
  - In any busy state: ignored.
- `in_valid` outside IDLE is ignored. No queuing; the upstream stage holds the sample until `in_ready` is high.

## Timing
- Reset, including reset asserted mid-operation: state = IDLE and acc = e_prev = 0. Outputs `ik` = `pk` = `dk` = 0 and `out_valid` = 0. `in_ready` = 1 in the first cycle after reset.
- Latency: accept at edge 0; `out_valid` is high in the cycle after edge 4, and new terms are visible in that same cycle.
- Throughput: one sample every 5 cycles. `in_ready` is low for 4 cycles after each accept.
- `out_valid` and the three terms change on the same edge. Terms stay stable until the next DONE, a clear, or reset.
- The gains are latched at accept, so gain changes while busy do not affect the sample in flight.

## Structure
- Shared in `constantes.h`: `N`, `FRAC`, SAT_MAX/SAT_MIN, and the FSM state encoding.
- Sub-module `fxp_mul_sat`: combinational signed N×(N+1) multiply, shift by FRAC, and saturate to N bits. It is instantiated once, and an operand mux is driven by the FSM state.
- The accumulator add-and-saturate and the N+1-bit difference are implemented inline in `pid_terms_gen`.

## Test plan
- Reset; kp=4096, ki=2048, kd=8192, error=4096 → `out_valid` after 4 cycles with pk=4096, ik=2048, dk=8192.
- Next sample error=4096, same gains → pk=4096, ik=4096, dk=0.
- kp=0x7FFFFF, error=0x7FFFFF → pk=0x7FFFFF. Then error=0x800000 → pk=0x800000.
- ki=4096, error=0x400000 three times → ik=0x400000, 0x7FFFFF, 0x7FFFFF (windup clamps at the limit). Then `clear_int` alone in IDLE → ik=0 with no `out_valid` pulse.
- `in_valid` held high continuously → accepts exactly every 5 cycles, no sample is lost while busy, and `in_ready` reads 1,0,0,0,0 repeating. `clear_int` pulsed during MUL_I → no effect.
- Reset asserted while in MUL_I → next cycle: all terms 0, `out_valid`=0, `in_ready`=1. Next sample error=4096 with kd=4096 → dk=4096 (e_prev was cleared).

Source files
------------

// File: rtl/pid_terms_gen_pkg.sv
// Shared constants and FSM state encoding for the PID term generator.
package pid_terms_gen_pkg;

    localparam int N_DEFAULT    = 24;
    localparam int FRAC_DEFAULT = 12;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL_P = 3'd1,
        MUL_I = 3'd2,
        MUL_D = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/pid_terms_gen_mul.sv
// Combinational signed N x (N+1) fixed-point multiply: full product,
// arithmetic shift by FRAC, saturate to N bits.
module fxp_mul_sat #(
    parameter int N    = 24,
    parameter int FRAC = 12
) (
    input  logic signed [N-1:0] a,
    input  logic signed [N:0]   b,
    output logic signed [N-1:0] y
);

    localparam int PW = 2 * N + 1;

    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shifted;
    logic        [N+1:0]  upper;

    assign a_ext   = $signed({{(N + 1){a[N-1]}}, a});
    assign b_ext   = $signed({{N{b[N]}}, b});
    assign prod    = a_ext * b_ext;
    assign shifted = prod >>> FRAC;
    assign upper   = shifted[PW-1:N-1];

    // The shifted value fits in N bits only when all bits above the N-bit sign agree.
    always_comb begin
        y = shifted[N-1:0];
        if (upper != '0 && upper != '1) begin
            y = shifted[PW-1] ? {1'b1, {(N - 1){1'b0}}} : {1'b0, {(N - 1){1'b1}}};
        end
    end

endmodule

// File: rtl/pid_terms_gen.sv
// PID term generator: one shared saturating multiplier sequenced over the
// P, I and D products, with the integral accumulator and previous error kept here.
module pid_terms_gen
    import pid_terms_gen_pkg::*;
#(
    parameter int N    = N_DEFAULT,
    parameter int FRAC = FRAC_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] error,
    input  logic [N-1:0] kp,
    input  logic [N-1:0] ki,
    input  logic [N-1:0] kd,
    input  logic         clear_int,
    output logic         out_valid,
    output logic [N-1:0] ik,
    output logic [N-1:0] pk,
    output logic [N-1:0] dk
);

    localparam logic [N-1:0] SAT_MAX = {1'b0, {(N - 1){1'b1}}};
    localparam logic [N-1:0] SAT_MIN = {1'b1, {(N - 1){1'b0}}};

    state_t state, state_next;

    logic [N-1:0] e_r, kp_r, ki_r, kd_r;
    logic [N-1:0] acc, e_prev, pk_next, dk_next;
    logic [N:0]   diff, acc_sum, mul_b;
    logic [N-1:0] mul_a, mul_y, acc_sat;

    assign diff    = {e_r[N-1], e_r} - {e_prev[N-1], e_prev};
    assign acc_sum = {acc[N-1], acc} + {mul_y[N-1], mul_y};
    assign acc_sat = (acc_sum[N] != acc_sum[N-1]) ? (acc_sum[N] ? SAT_MIN : SAT_MAX)
                                                  : acc_sum[N-1:0];
    assign in_ready = (state == IDLE);

    fxp_mul_sat #(.N(N), .FRAC(FRAC)) u_mul (
        .a (mul_a),
        .b (mul_b),
        .y (mul_y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the operand mux feeding the shared multiplier.
    always_comb begin
        state_next = state;
        mul_a      = kp_r;
        mul_b      = {e_r[N-1], e_r};
        case (state)
            IDLE:  if (in_valid) state_next = MUL_P;
            MUL_P: state_next = MUL_I;
            MUL_I: begin
                state_next = MUL_D;
                mul_a      = ki_r;
            end
            MUL_D: begin
                state_next = DONE;
                mul_a      = kd_r;
                mul_b      = diff;
            end
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operands are captured on accept so gain changes while busy are invisible.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_r       <= '0;
            kp_r      <= '0;
            ki_r      <= '0;
            kd_r      <= '0;
            acc       <= '0;
            e_prev    <= '0;
            pk_next   <= '0;
            dk_next   <= '0;
            ik        <= '0;
            pk        <= '0;
            dk        <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        e_r  <= error;
                        kp_r <= kp;
                        ki_r <= ki;
                        kd_r <= kd;
                        if (clear_int) acc <= '0;
                    end else if (clear_int) begin
                        acc <= '0;
                        ik  <= '0;
                    end
                end
                MUL_P: pk_next <= mul_y;
                MUL_I: acc     <= acc_sat;
                MUL_D: dk_next <= mul_y;
                DONE: begin
                    pk        <= pk_next;
                    ik        <= acc;
                    dk        <= dk_next;
                    out_valid <= 1'b1;
                    e_prev    <= e_r;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pid_terms_gen.sv
// Self-checking bench for pid_terms_gen against an arithmetic PID reference model.
module tb_pid_terms_gen;

    localparam int N    = 24;
    localparam int FRAC = 12;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] error, kp, ki, kd;
    logic         clear_int;
    logic         out_valid;
    logic [N-1:0] ik, pk, dk;

    int     vectors     = 0;
    int     miscompares = 0;
    longint cycle       = 0;
    longint last_accept = -1;

    longint       m_acc, m_eprev;
    logic [N-1:0] m_ik, m_pk, m_dk;

    pid_terms_gen #(.N(N), .FRAC(FRAC)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .error     (error),
        .kp        (kp),
        .ki        (ki),
        .kd        (kd),
        .clear_int (clear_int),
        .out_valid (out_valid),
        .ik        (ik),
        .pk        (pk),
        .dk        (dk)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic longint sat(input longint v);
        if (v > 64'sd8388607) return 64'sd8388607;
        if (v < -64'sd8388608) return -64'sd8388608;
        return v;
    endfunction

    function automatic longint fmul(input longint a, input longint b);
        longint p;
        p = a * b;
        return sat(p >>> FRAC);
    endfunction

    function automatic longint sx(input logic [N-1:0] v);
        return longint'($signed(v));
    endfunction

    function automatic logic [N-1:0] rnd();
        logic [31:0] r;
        r = $urandom;
        return r[N-1:0];
    endfunction

    task automatic check_output(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // mode 0: plain, 1: in_valid held high, 2: clear_int pulse in MUL_I, 3: reset in MUL_I
    task automatic apply_stimulus(input logic [N-1:0] e, input logic [N-1:0] kpv,
                                  input logic [N-1:0] kiv, input logic [N-1:0] kdv,
                                  input logic clr, input int mode);
        int     guard;
        longint acc_cycle;
        error     = e;
        kp        = kpv;
        ki        = kiv;
        kd        = kdv;
        clear_int = clr;
        in_valid  = 1'b1;
        guard     = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check_output("ready_wait", N'(in_ready), N'(1));
        @(posedge clk);
        #1;
        acc_cycle = cycle;
        if (mode == 1 && last_accept >= 0)
            check_output("accept_spacing", N'(acc_cycle - last_accept), N'(5));
        last_accept = acc_cycle;
        if (mode != 1) in_valid = 1'b0;
        clear_int = 1'b0;
        error     = rnd();
        kp        = rnd();
        ki        = rnd();
        kd        = rnd();

        if (mode == 3) begin
            m_acc   = 0;
            m_eprev = 0;
            m_ik    = '0;
            m_pk    = '0;
            m_dk    = '0;
        end else begin
            if (clr) m_acc = 0;
            m_pk    = N'(fmul(sx(kpv), sx(e)));
            m_acc   = sat(m_acc + fmul(sx(kiv), sx(e)));
            m_dk    = N'(fmul(sx(kdv), sx(e) - m_eprev));
            m_eprev = sx(e);
            m_ik    = N'(m_acc);
        end

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_output("busy_ready", N'(in_ready), N'(0));
            check_output("busy_valid", N'(out_valid), N'(0));
            if (mode == 2 && i == 1) clear_int = 1'b1;
            if (mode == 2 && i == 2) clear_int = 1'b0;
            if (mode == 3 && i == 1) begin
                reset = 1'b1;
                @(negedge clk);
                check_output("rst_ready", N'(in_ready), N'(1));
                check_output("rst_valid", N'(out_valid), N'(0));
                check_output("rst_ik", ik, m_ik);
                check_output("rst_pk", pk, m_pk);
                check_output("rst_dk", dk, m_dk);
                reset = 1'b0;
                return;
            end
        end
        @(negedge clk);
        check_output("done_valid", N'(out_valid), N'(1));
        check_output("done_ready", N'(in_ready), N'(1));
        check_output("ik", ik, m_ik);
        check_output("pk", pk, m_pk);
        check_output("dk", dk, m_dk);
    endtask

    task automatic clear_only();
        clear_int = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        m_acc = 0;
        m_ik  = '0;
        check_output("clr_ik", ik, m_ik);
        check_output("clr_pk", pk, m_pk);
        check_output("clr_valid", N'(out_valid), N'(0));
        check_output("clr_ready", N'(in_ready), N'(1));
        clear_int = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        clear_int = 1'b0;
        error     = '0;
        kp        = '0;
        ki        = '0;
        kd        = '0;
        m_acc     = 0;
        m_eprev   = 0;
        m_ik      = '0;
        m_pk      = '0;
        m_dk      = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_output("reset_ready", N'(in_ready), N'(1));
        check_output("reset_valid", N'(out_valid), N'(0));
        check_output("reset_ik", ik, '0);
        check_output("reset_pk", pk, '0);
        check_output("reset_dk", dk, '0);

        $display("[TB] directed samples");
        apply_stimulus(24'd4096, 24'd4096, 24'd2048, 24'd8192, 1'b0, 0);
        apply_stimulus(24'd4096, 24'd4096, 24'd2048, 24'd8192, 1'b0, 0);
        apply_stimulus(24'h7FFFFF, 24'h7FFFFF, 24'd0, 24'd0, 1'b0, 0);
        apply_stimulus(24'h800000, 24'h7FFFFF, 24'd0, 24'd0, 1'b0, 0);

        $display("[TB] integral windup and clear");
        apply_stimulus(24'h400000, 24'd0, 24'd4096, 24'd0, 1'b1, 0);
        apply_stimulus(24'h400000, 24'd0, 24'd4096, 24'd0, 1'b0, 0);
        apply_stimulus(24'h400000, 24'd0, 24'd4096, 24'd0, 1'b0, 0);
        clear_only();

        $display("[TB] back-to-back with in_valid held high");
        last_accept = -1;
        for (int i = 0; i < 4; i++)
            apply_stimulus(rnd(), rnd(), rnd(), rnd(), 1'b0, 1);
        in_valid = 1'b0;

        $display("[TB] clear_int while busy, reset while busy");
        apply_stimulus(rnd(), rnd(), rnd(), rnd(), 1'b0, 2);
        apply_stimulus(rnd(), rnd(), rnd(), rnd(), 1'b0, 3);
        apply_stimulus(24'd4096, 24'd0, 24'd0, 24'd4096, 1'b0, 0);

        $display("[TB] random samples");
        for (int i = 0; i < 20; i++)
            apply_stimulus(rnd(), rnd(), rnd(), rnd(), ($urandom_range(0, 7) == 0), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
